// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the writeback write-port encoder.
//   WB_N_REQ  : number of requester slots (2**WB_ADDR_W)
//   WB_ADDR_W : width of the encoded register-write address
//   WB_DATA_W : register-write data width
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_N_REQ  = 8;
  localparam int WB_ADDR_W = 3;
  localparam int WB_DATA_W = 64;

  typedef logic [WB_ADDR_W-1:0] wb_addr_t;
  typedef logic [WB_DATA_W-1:0] wb_data_t;

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin picker: rotates the eligible vector so that
// slot 'ptr' sits at position 0, priority-encodes the lowest set bit, and
// rotates the resulting offset back into an absolute slot index.
// Ports:
//   eligible [N_REQ]  : per-slot eligibility
//   ptr      [ADDR_W] : highest-priority slot
//   valid             : at least one slot eligible
//   g        [ADDR_W] : winning slot index (meaningful when valid=1)
// -----------------------------------------------------------------------------
module rr_priority_pick
  import wb_pkg::*;
#(
  parameter int N_REQ  = WB_N_REQ,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [N_REQ-1:0]  eligible,
  input  logic [ADDR_W-1:0] ptr,
  output logic              valid,
  output logic [ADDR_W-1:0] g
);

  logic [N_REQ-1:0]  w_rot;
  logic [ADDR_W-1:0] w_off;

  // N_REQ == 2**ADDR_W, so ADDR_W-bit addition wraps modulo N_REQ for free.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [ADDR_W-1:0] w_src;
      assign w_src     = ptr + ADDR_W'(gi);
      assign w_rot[gi] = eligible[w_src];
    end
  endgenerate

  // Lowest rotated position wins: scan downwards so the last hit is the lowest.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ADDR_W'(k);
      end
    end
  end

  assign valid = |w_rot;
  assign g     = ptr + w_off;

endmodule

// File: rtl/wb_write_encoder.sv
// -----------------------------------------------------------------------------
// wb_write_encoder
// Round-robin encoder that merges up to N_REQ writeback requesters into one
// registered register-file write port (regwrite/wraddr/wrdata) with a
// registered one-hot acknowledge back to the requesters.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   req      : per-slot request, held until acked
//   reqdata  : packed per-slot data, slot i at [i*DATA_W +: DATA_W]
//   hold     : stall, blocks new grants
//   regwrite : registered write enable
//   wraddr   : registered index of the granted slot
//   wrdata   : registered data of the granted slot
//   ack      : registered one-hot acknowledge (decode of wraddr when regwrite)
//   busy     : combinational, any eligible request pending
// -----------------------------------------------------------------------------
module wb_write_encoder
  import wb_pkg::*;
#(
  parameter int N_REQ  = WB_N_REQ,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] reqdata,
  input  logic                    hold,
  output logic                    regwrite,
  output logic [ADDR_W-1:0]       wraddr,
  output logic [DATA_W-1:0]       wrdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy
);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wraddr;
  logic [DATA_W-1:0] r_wrdata;
  logic [N_REQ-1:0]  r_ack;

  logic [N_REQ-1:0]  w_eligible;
  logic              w_valid;
  logic [ADDR_W-1:0] w_g;
  logic [DATA_W-1:0] w_slice [N_REQ];
  logic [N_REQ-1:0]  w_grant_onehot;

  // A slot acked this cycle still has req high; masking it prevents a
  // double grant of the same transfer.
  assign w_eligible = req & ~r_ack;
  assign busy       = |w_eligible;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slice[gi] = reqdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_priority_pick #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W)
  ) u_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .valid    (w_valid),
    .g        (w_g)
  );

  assign w_grant_onehot = N_REQ'(1) << w_g;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_regwrite <= 1'b0;
      r_wraddr   <= '0;
      r_wrdata   <= '0;
      r_ack      <= '0;
    end else if (hold || !w_valid) begin
      // wraddr/wrdata intentionally keep their last values.
      r_regwrite <= 1'b0;
      r_ack      <= '0;
    end else begin
      r_regwrite <= 1'b1;
      r_wraddr   <= w_g;
      r_wrdata   <= w_slice[w_g];
      r_ack      <= w_grant_onehot;
      r_ptr      <= w_g + ADDR_W'(1);
    end
  end

  assign regwrite = r_regwrite;
  assign wraddr   = r_wraddr;
  assign wrdata   = r_wrdata;
  assign ack      = r_ack;

endmodule

// File: tb/tb_wb_write_encoder.sv
module tb_wb_write_encoder;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] reqdata;
  logic          hold;
  logic          regwrite;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic [N-1:0]  ack;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model state: output values expected after the latest edge.
  int            m_ptr;
  logic [N-1:0]  m_ack;
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  wb_write_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .reqdata  (reqdata),
    .hold     (hold),
    .regwrite (regwrite),
    .wraddr   (wraddr),
    .wrdata   (wrdata),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, applying the arbitration rules to the model, and
  // return #1 after the edge so outputs can be sampled.
  task automatic step();
    int g;
    g = -1;
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_ack = '0; m_rw = 1'b0; m_addr = '0; m_data = '0;
    end else if (hold) begin
      m_rw = 1'b0; m_ack = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (g < 0 && req[s] && !m_ack[s]) g = s;
      end
      if (g >= 0) begin
        m_rw   = 1'b1;
        m_addr = AW'(g);
        m_data = reqdata[g*DW +: DW];
        m_ack  = '0;
        m_ack[g] = 1'b1;
        m_ptr  = (g + 1) % N;
      end else begin
        m_rw = 1'b0; m_ack = '0;
      end
    end
    #1;
  endtask

  task automatic set_data(input int slot, input logic [DW-1:0] d);
    reqdata[slot*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; req = 8'hFF;
    for (int i = 0; i < N; i++) set_data(i, {$urandom, $urandom});
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (regwrite !== 1'b0 || ack !== 8'h00 || wraddr !== 3'd0 || wrdata !== 64'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got rw=%b ack=%h addr=%0d data=%h want 0/00/0/0",
                 c, regwrite, ack, wraddr, wrdata);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd0 || ack !== 8'h01 || wrdata !== reqdata[0 +: DW]) begin
      errors++;
      $display("FAIL reset_first_grant got rw=%b addr=%0d ack=%h data=%h want 1/0/01/%h",
               regwrite, wraddr, ack, wrdata, reqdata[0 +: DW]);
    end
    @(negedge clk);
    req = 8'h00;
    step();
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    // ptr is 1 after the first grant of slot 0.
    set_data(5, 64'hDEAD_BEEF);
    req = 8'h20;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd5 || wrdata !== 64'hDEAD_BEEF || ack !== 8'h20) begin
      errors++;
      $display("FAIL single_grant got rw=%b addr=%0d data=%h ack=%h want 1/5/deadbeef/20",
               regwrite, wraddr, wrdata, ack);
    end
    @(negedge clk);
    req = 8'h00;
    step();
    checks++;
    if (regwrite !== 1'b0 || ack !== 8'h00) begin
      errors++;
      $display("FAIL single_idle got rw=%b ack=%h want 0/00", regwrite, ack);
    end
    @(negedge clk);
    $display("test_single done");
  endtask

  task automatic test_round_robin_wrap();
    logic [N*AW-1:0] order;
    order = {3'd0, 3'd7, 3'd6};
    for (int i = 0; i < N; i++) set_data(i, {$urandom, $urandom});
    req = 8'hC1;
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] want;
      want = order[i*AW +: AW];
      step();
      checks++;
      if (regwrite !== 1'b1 || wraddr !== want || ack !== (8'h01 << want) ||
          wrdata !== reqdata[int'(want)*DW +: DW]) begin
        errors++;
        $display("FAIL rr_order idx=%0d got rw=%b addr=%0d ack=%h want addr=%0d", i, regwrite, wraddr, ack, want);
      end
      @(negedge clk);
      req[want] = 1'b0;
    end
    step();
    checks++;
    if (regwrite !== 1'b0) begin
      errors++;
      $display("FAIL rr_end got rw=%b want 0", regwrite);
    end
    @(negedge clk);
    $display("test_round_robin_wrap done");
  endtask

  task automatic test_saturation();
    int cnt [N];
    int last;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    last = -1;
    req = 8'hFF;
    for (int c = 0; c < 32; c++) begin
      step();
      checks++;
      if (regwrite !== 1'b1 || wraddr !== m_addr || ack !== m_ack) begin
        errors++;
        $display("FAIL sat_grant cyc=%0d got rw=%b addr=%0d want 1/%0d", c, regwrite, wraddr, m_addr);
      end
      if (regwrite === 1'b1) begin
        checks++;
        if (int'(wraddr) == last) begin
          errors++;
          $display("FAIL sat_repeat cyc=%0d got slot %0d twice, want different", c, wraddr);
        end
        cnt[wraddr]++;
        last = int'(wraddr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 4) begin
        errors++;
        $display("FAIL sat_count slot=%0d got %0d want 4", i, cnt[i]);
      end
    end
    req = 8'h00;
    step();
    @(negedge clk);
    $display("test_saturation done");
  endtask

  task automatic test_hold();
    req = 8'h0A; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_busy cyc=%0d got %b want 1", c, busy);
      end
      step();
      checks++;
      if (regwrite !== 1'b0 || ack !== 8'h00) begin
        errors++;
        $display("FAIL hold_block cyc=%0d got rw=%b ack=%h want 0/00", c, regwrite, ack);
      end
      @(negedge clk);
    end
    hold = 1'b0;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd1) begin
      errors++;
      $display("FAIL hold_release1 got rw=%b addr=%0d want 1/1", regwrite, wraddr);
    end
    @(negedge clk);
    req[1] = 1'b0;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd3) begin
      errors++;
      $display("FAIL hold_release2 got rw=%b addr=%0d want 1/3", regwrite, wraddr);
    end
    @(negedge clk);
    req[3] = 1'b0;
    step();
    @(negedge clk);
    $display("test_hold done");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d2;
    set_data(2, {$urandom, $urandom});
    req = 8'h04;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd2) begin
      errors++;
      $display("FAIL midrst_pre got rw=%b addr=%0d want 1/2", regwrite, wraddr);
    end
    @(negedge clk);
    reset = 1'b1;
    d2 = {$urandom, $urandom};
    set_data(2, d2);
    step();
    checks++;
    if (regwrite !== 1'b0 || ack !== 8'h00) begin
      errors++;
      $display("FAIL midrst_during got rw=%b ack=%h want 0/00", regwrite, ack);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (regwrite !== 1'b1 || wraddr !== 3'd2 || wrdata !== d2 || ack !== 8'h04) begin
      errors++;
      $display("FAIL midrst_after got rw=%b addr=%0d data=%h want 1/2/%h", regwrite, wraddr, wrdata, d2);
    end
    @(negedge clk);
    req = 8'h00;
    step();
    @(negedge clk);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      // Acked requesters drop; idle ones may raise with fresh data.
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          set_data(i, {$urandom, $urandom});
          req[i] = 1'b1;
        end
      end
      hold  = ($urandom_range(3) == 0);
      reset = ($urandom_range(49) == 0);
      #1;
      checks++;
      if (busy !== |(req & ~m_ack)) begin
        errors++;
        $display("FAIL rnd_busy cyc=%0d got %b want %b", c, busy, |(req & ~m_ack));
      end
      step();
      checks++;
      if (regwrite !== m_rw || ack !== m_ack || wraddr !== m_addr || wrdata !== m_data) begin
        errors++;
        $display("FAIL rnd_out cyc=%0d got rw=%b ack=%h addr=%0d data=%h want %b/%h/%0d/%h",
                 c, regwrite, ack, wraddr, wrdata, m_rw, m_ack, m_addr, m_data);
      end
      checks++;
      if (!$onehot0(ack) || regwrite !== |ack || (regwrite && ack !== (8'h01 << wraddr))) begin
        errors++;
        $display("FAIL rnd_invariant cyc=%0d got rw=%b ack=%h addr=%0d want consistent", c, regwrite, ack, wraddr);
      end
      @(negedge clk);
    end
    reset = 1'b0; hold = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req = '0; reqdata = '0;
    m_ptr = 0; m_ack = '0; m_rw = 1'b0; m_addr = '0; m_data = '0;
    test_reset();
    test_single();
    test_round_robin_wrap();
    test_saturation();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
